// File: rtl/flag_register_unit_pkg.sv
// Shared flag-set definitions for the NZCV flag register unit and its shadow stack.
package flag_register_unit_pkg;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef logic [3:0] flags_t;

  localparam flags_t MASK_ALL = 4'b1111;
  localparam flags_t MASK_NZ  = 4'b1100;

  function automatic flags_t pack_flags(input logic n, input logic z,
                                        input logic c, input logic v);
    flags_t f;
    f[FLAG_N] = n;
    f[FLAG_Z] = z;
    f[FLAG_C] = c;
    f[FLAG_V] = v;
    return f;
  endfunction

endpackage

// File: rtl/flag_register_unit_if.sv
// ALU/status/stack-control bundle between the datapath (master) and the flag unit (slave).
interface flag_register_unit_if #(
  parameter int DATA_WIDTH = 32
);
  import flag_register_unit_pkg::*;

  logic [DATA_WIDTH-1:0] alu_result;
  logic                  alu_carry;
  logic                  alu_overflow;
  logic                  update_en;
  flags_t                update_mask;
  logic                  load_en;
  flags_t                load_value;
  logic                  push;
  logic                  pop;
  logic                  negative_flag;
  logic                  zero_flag;
  logic                  carry_flag;
  logic                  overflow_flag;
  logic                  stack_empty;
  logic                  stack_full;
  logic                  stack_error;

  modport master (
    output alu_result, alu_carry, alu_overflow, update_en, update_mask,
           load_en, load_value, push, pop,
    input  negative_flag, zero_flag, carry_flag, overflow_flag,
           stack_empty, stack_full, stack_error
  );

  modport slave (
    input  alu_result, alu_carry, alu_overflow, update_en, update_mask,
           load_en, load_value, push, pop,
    output negative_flag, zero_flag, carry_flag, overflow_flag,
           stack_empty, stack_full, stack_error
  );

endinterface

// File: rtl/flag_register_unit_shadow_stack.sv
// flag_shadow_stack: small LIFO of saved flag sets; callers only issue legal push/pop.
module flag_shadow_stack
  import flag_register_unit_pkg::*;
#(
  parameter int STACK_DEPTH = 4
) (
  input  logic   clock,
  input  logic   reset,
  input  logic   push_valid,
  input  logic   pop_valid,
  input  flags_t push_data,
  output flags_t top_data,
  output logic   empty,
  output logic   full
);

  localparam int PW = $clog2(STACK_DEPTH);

  flags_t          mem [STACK_DEPTH];
  logic [PW:0]     count_reg;
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;

  assign wr_ptr   = count_reg[PW-1:0];
  assign rd_ptr   = wr_ptr - PW'(1);
  assign top_data = mem[rd_ptr];
  assign empty    = (count_reg == '0);
  assign full     = (count_reg == (PW+1)'(STACK_DEPTH));

  // Entries are not reset; only the count defines what is valid.
  always_ff @(posedge clock) begin
    if (push_valid) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_reg <= '0;
    end else if (push_valid) begin
      count_reg <= count_reg + 1'b1;
    end else if (pop_valid) begin
      count_reg <= count_reg - 1'b1;
    end
  end

endmodule

// File: rtl/flag_register_unit.sv
// NZCV flag register with ALU capture, direct load and interrupt shadow stack.
// Optional FLAG_FORWARD_EN: flag outputs bypass the register with next-flag values.
module flag_register_unit
  import flag_register_unit_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int STACK_DEPTH = 4
) (
  input logic                 clock,
  input logic                 reset,
  flag_register_unit_if.slave bus
);

  flags_t flags_reg;
  flags_t flags_next;
  flags_t alu_flags;
  flags_t upd_flags;
  flags_t stack_top;
  logic   error_reg;
  logic   stk_empty;
  logic   stk_full;
  logic   push_ok;
  logic   pop_ok;
  logic   error_set;

  assign alu_flags = pack_flags(bus.alu_result[DATA_WIDTH-1],
                                (bus.alu_result == '0),
                                bus.alu_carry,
                                bus.alu_overflow);

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_mask
      assign upd_flags[gi] = bus.update_mask[gi] ? alu_flags[gi] : flags_reg[gi];
    end
  endgenerate

  // Simultaneous push and pop is treated as an error and neither takes effect.
  assign push_ok   = bus.push && !bus.pop && !stk_full;
  assign pop_ok    = bus.pop && !bus.push && !stk_empty;
  assign error_set = (bus.push && bus.pop)
                   || (bus.push && stk_full)
                   || (bus.pop && stk_empty);

  always_comb begin
    flags_next = flags_reg;
    if (pop_ok) begin
      flags_next = stack_top;
    end else if (bus.load_en) begin
      flags_next = bus.load_value;
    end else if (bus.update_en) begin
      flags_next = upd_flags;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      flags_reg <= '0;
      error_reg <= 1'b0;
    end else begin
      flags_reg <= flags_next;
      if (error_set) begin
        error_reg <= 1'b1;
      end
    end
  end

  flag_shadow_stack #(
    .STACK_DEPTH (STACK_DEPTH)
  ) u_stack (
    .clock      (clock),
    .reset      (reset),
    .push_valid (push_ok),
    .pop_valid  (pop_ok),
    .push_data  (flags_reg),
    .top_data   (stack_top),
    .empty      (stk_empty),
    .full       (stk_full)
  );

`ifdef FLAG_FORWARD_EN
  assign bus.negative_flag = flags_next[FLAG_N];
  assign bus.zero_flag     = flags_next[FLAG_Z];
  assign bus.carry_flag    = flags_next[FLAG_C];
  assign bus.overflow_flag = flags_next[FLAG_V];
`else
  assign bus.negative_flag = flags_reg[FLAG_N];
  assign bus.zero_flag     = flags_reg[FLAG_Z];
  assign bus.carry_flag    = flags_reg[FLAG_C];
  assign bus.overflow_flag = flags_reg[FLAG_V];
`endif

  assign bus.stack_empty = stk_empty;
  assign bus.stack_full  = stk_full;
  assign bus.stack_error = error_reg;

endmodule

// File: tb/tb_flag_register_unit.sv
// Directed self-checking bench for flag_register_unit (works with or without FLAG_FORWARD_EN).
module tb_flag_register_unit;
  import flag_register_unit_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;

  flag_register_unit_if #(.DATA_WIDTH(32)) bus ();

  flag_register_unit #(
    .DATA_WIDTH  (32),
    .STACK_DEPTH (4)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  function automatic flags_t obs_flags();
    return {bus.negative_flag, bus.zero_flag, bus.carry_flag, bus.overflow_flag};
  endfunction

  function automatic logic [2:0] obs_stack();
    return {bus.stack_empty, bus.stack_full, bus.stack_error};
  endfunction

  task automatic chk(input string tag, input logic [3:0] observed, input logic [3:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, observed, expected);
    end
    $display("check %-14s observed=%b expected=%b", tag, observed, expected);
  endtask

  task automatic idle();
    bus.alu_result   = '0;
    bus.alu_carry    = 1'b0;
    bus.alu_overflow = 1'b0;
    bus.update_en    = 1'b0;
    bus.update_mask  = '0;
    bus.load_en      = 1'b0;
    bus.load_value   = '0;
    bus.push         = 1'b0;
    bus.pop          = 1'b0;
  endtask

  // Clock the driven inputs in, then return to idle so outputs equal the registered state.
  task automatic step();
    @(posedge clock);
    #1;
    idle();
    #1;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0;
    #2;
    chk("rst_flags", obs_flags(), 4'b0000);
    chk("rst_stack", {1'b0, obs_stack()}, 4'b0100);
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic load(input flags_t v, input logic do_push, input logic do_pop);
    bus.load_en    = 1'b1;
    bus.load_value = v;
    bus.push       = do_push;
    bus.pop        = do_pop;
    step();
  endtask

  initial begin
    idle();
    do_reset();

    // ALU capture with full mask, then N/Z-only mask
    bus.update_en = 1'b1; bus.update_mask = MASK_ALL;
    bus.alu_result = 32'h0; bus.alu_carry = 1'b1; bus.alu_overflow = 1'b0;
    step();
    chk("upd_all", obs_flags(), 4'b0110);
    bus.update_en = 1'b1; bus.update_mask = MASK_NZ;
    bus.alu_result = 32'h8000_0000; bus.alu_carry = 1'b0; bus.alu_overflow = 1'b1;
    step();
    chk("upd_nz", obs_flags(), 4'b1010);

    // Load beats update in the same cycle
    bus.update_en = 1'b1; bus.update_mask = MASK_ALL;
    bus.alu_result = 32'h0; bus.alu_carry = 1'b0; bus.alu_overflow = 1'b1;
    bus.load_en = 1'b1; bus.load_value = 4'b1010;
    step();
    chk("load_wins", obs_flags(), 4'b1010);

    // Save / clobber / restore round trip
    load(4'b0110, 1'b0, 1'b0);
    bus.push = 1'b1;
    step();
    chk("push_flags", obs_flags(), 4'b0110);
    chk("push_stack", {1'b0, obs_stack()}, 4'b0000);
    load(4'b0001, 1'b0, 1'b0);
    chk("load_0001", obs_flags(), 4'b0001);
    bus.pop = 1'b1;
    step();
    chk("pop_restore", obs_flags(), 4'b0110);
    chk("pop_stack", {1'b0, obs_stack()}, 4'b0100);

    // Fill the stack; each push saves the pre-load flags
    load(4'b0001, 1'b0, 1'b0);
    load(4'b0010, 1'b1, 1'b0);
    load(4'b0011, 1'b1, 1'b0);
    load(4'b0100, 1'b1, 1'b0);
    chk("fill3_stack", {1'b0, obs_stack()}, 4'b0000);
    load(4'b0101, 1'b1, 1'b0);
    chk("full_stack", {1'b0, obs_stack()}, 4'b0010);
    load(4'b0111, 1'b1, 1'b0);
    chk("ovf_flags", obs_flags(), 4'b0111);
    chk("ovf_stack", {1'b0, obs_stack()}, 4'b0011);
    bus.pop = 1'b1; step(); chk("pop1", obs_flags(), 4'b0100);
    bus.pop = 1'b1; step(); chk("pop2", obs_flags(), 4'b0011);
    bus.pop = 1'b1; step(); chk("pop3", obs_flags(), 4'b0010);
    bus.pop = 1'b1; step(); chk("pop4", obs_flags(), 4'b0001);
    chk("drained", {1'b0, obs_stack()}, 4'b0101);

    // Reset mid-operation discards saved entries and the sticky error
    load(4'b1100, 1'b1, 1'b0);
    do_reset();
    chk("rst2_flags", obs_flags(), 4'b0000);

    // Pop on empty: error, update still applies
    load(4'b0100, 1'b0, 1'b0);
    bus.pop = 1'b1; bus.update_en = 1'b1; bus.update_mask = MASK_ALL;
    bus.alu_result = 32'h1; bus.alu_carry = 1'b0; bus.alu_overflow = 1'b0;
`ifdef FLAG_FORWARD_EN
    #1;
    chk("fwd_zero", {3'b000, bus.zero_flag}, 4'b0000);
`endif
    step();
    chk("popempty_flg", obs_flags(), 4'b0000);
    chk("popempty_stk", {1'b0, obs_stack()}, 4'b0101);

    // Push and pop together: both dropped, load still applies
    do_reset();
    load(4'b1111, 1'b0, 1'b0);
    bus.push = 1'b1;
    step();
    load(4'b0000, 1'b1, 1'b1);
    chk("pushpop_flg", obs_flags(), 4'b0000);
    chk("pushpop_stk", {1'b0, obs_stack()}, 4'b0001);
    bus.pop = 1'b1;
    step();
    chk("pushpop_rest", obs_flags(), 4'b1111);
    chk("pushpop_empty", {1'b0, obs_stack()}, 4'b0101);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    errors++;
    $display("FAIL timeout observed=running expected=finished");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
